// File: rtl/ascii_case_stream.sv
// Streaming ASCII case converter: LANES bytes per beat, one output register stage,
// and a saturating count of the bytes that were actually changed.
module ascii_case_stream #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     conv_count
);

    // Wide enough to hold the counter plus a full beat's increment without overflow.
    localparam int unsigned SumW = CNT_W + 6;

    logic                 m_valid_q, m_valid_d;
    logic [8*LANES-1:0]   m_data_q, m_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [8*LANES-1:0]   conv_data;
    logic [SumW-1:0]      n_changed;
    logic [SumW-1:0]      cnt_sum;
    logic                 accept;

    // mode[0] raises lowercase letters, mode[1] lowers uppercase; both set toggles case.
    function automatic logic flip_lane(input logic [7:0] b, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        is_lower = (b >= 8'd97) && (b <= 8'd122);
        is_upper = (b >= 8'd65) && (b <= 8'd90);
        return (m[0] && is_lower) || (m[1] && is_upper);
    endfunction

    always_comb begin
        conv_data = s_data;
        n_changed = '0;
        for (int k = 0; k < LANES; k++) begin
            if (flip_lane(s_data[8*k +: 8], mode)) begin
                conv_data[8*k + 5] = ~s_data[8*k + 5];
                n_changed          = n_changed + SumW'(1);
            end
        end
    end

    assign s_ready = !rst && (!m_valid_q || m_ready);
    assign accept  = s_valid && s_ready;
    assign cnt_sum = SumW'(cnt_q) + n_changed;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = conv_data;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (|cnt_sum[SumW-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: directed scenarios plus random traffic, every cycle
// compared against a byte-level reference model of the stream.
module tb_ascii_case_stream;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 16;

    logic                clk;
    logic                rst;
    logic [1:0]          mode;
    logic                s_valid;
    logic                s_ready;
    logic [8*LANES-1:0]  s_data;
    logic                m_valid;
    logic                m_ready;
    logic [8*LANES-1:0]  m_data;
    logic                cnt_clr;
    logic [CNT_W-1:0]    conv_count;

    ascii_case_stream #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .cnt_clr    (cnt_clr),
        .conv_count (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    bit          exp_valid;
    logic [31:0] exp_data;
    int          exp_cnt;
    int          delivered;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int conv_byte(input int b, input int m, output bit changed);
        changed = 1'b0;
        if ((m == 1 || m == 3) && b >= 97 && b <= 122) begin
            changed = 1'b1;
            return b - 32;
        end
        if ((m == 2 || m == 3) && b >= 65 && b <= 90) begin
            changed = 1'b1;
            return b + 32;
        end
        return b;
    endfunction

    function automatic logic [31:0] pack(input int b0, input int b1, input int b2, input int b3);
        return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // One clock cycle: drive, check ready, clock, advance the model, check outputs.
    task automatic step(input bit r, input bit sv, input logic [31:0] d, input logic [1:0] md,
                        input bit mr, input bit clr, input bit full_chk);
        bit          rdy;
        bit          acc;
        bit          ch;
        int          inc;
        logic [31:0] cd;
        @(negedge clk);
        rst = r; s_valid = sv; s_data = d; mode = md; m_ready = mr; cnt_clr = clr;
        #1;
        rdy = !r && (!exp_valid || mr);
        if (full_chk) check("s_ready", 64'(s_ready), 64'(rdy));
        acc = sv && rdy;
        inc = 0;
        for (int k = 0; k < 4; k++) begin
            int v;
            v = conv_byte(int'(d[8*k +: 8]), int'(md), ch);
            cd[8*k +: 8] = v[7:0];
            if (ch) inc++;
        end
        @(posedge clk);
        if (r) begin
            exp_valid = 1'b0; exp_data = '0; exp_cnt = 0;
        end else begin
            if (exp_valid && mr) delivered++;
            if (acc) begin
                exp_valid = 1'b1; exp_data = cd;
            end else if (mr) begin
                exp_valid = 1'b0;
            end
            if (clr) exp_cnt = 0;
            else if (acc) exp_cnt = (exp_cnt + inc > 65535) ? 65535 : exp_cnt + inc;
        end
        #1;
        if (full_chk) begin
            check("m_valid", 64'(m_valid), 64'(exp_valid));
            check("m_data", 64'(m_data), 64'(exp_data));
            check("conv_count", 64'(conv_count), 64'(exp_cnt));
        end
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
                0: d[8*k +: 8] = 8'($urandom_range(97, 122));
                1: d[8*k +: 8] = 8'($urandom_range(65, 90));
                default: d[8*k +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return d;
    endfunction

    initial begin
        logic [31:0] beat;
        int          start_del;
        exp_valid = 1'b0; exp_data = '0; exp_cnt = 0; delivered = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; mode = 2'b00; m_ready = 1'b0; cnt_clr = 1'b0;

        // Reset, with traffic offered that must be ignored
        step(1, 1, pack(97, 98, 99, 100), 2'b01, 1, 0, 1);
        step(1, 1, pack(97, 98, 99, 100), 2'b01, 0, 0, 1);

        // Non-letters in upper mode
        step(0, 1, pack(40, 72, 183, 131), 2'b01, 1, 0, 1);
        // Same letter beat in every mode
        beat = pack(97, 122, 109, 71);
        step(0, 1, beat, 2'b01, 1, 0, 1);
        check("cnt_after_upper", 64'(conv_count), 64'd3);
        step(0, 1, beat, 2'b10, 1, 0, 1);
        check("cnt_after_lower", 64'(conv_count), 64'd4);
        step(0, 1, beat, 2'b11, 1, 0, 1);
        check("data_toggle", 64'(m_data), 64'(pack(65, 90, 77, 103)));
        step(0, 1, beat, 2'b00, 1, 0, 1);
        check("cnt_after_pass", 64'(conv_count), 64'd8);

        // Boundary bytes in toggle mode and high bytes in all modes
        step(0, 1, pack(64, 91, 96, 123), 2'b11, 1, 0, 1);
        step(0, 1, pack(65, 90, 97, 122), 2'b11, 1, 0, 1);
        check("boundary_toggle", 64'(m_data), 64'(pack(97, 122, 65, 90)));
        for (int m = 0; m < 4; m++) step(0, 1, pack(207, 235, 146, 148), 2'(m), 1, 0, 1);
        step(0, 0, '0, 2'b00, 1, 0, 1);

        // Back-pressure: second beat held off for three cycles, mode changes ignored
        start_del = delivered;
        step(0, 1, pack(104, 105, 33, 90), 2'b01, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, pack(65, 66, 67, 68), 2'b10, 0, 0, 1);
        step(0, 1, pack(65, 66, 67, 68), 2'b10, 1, 0, 1);
        check("bp_second_beat", 64'(m_data), 64'(pack(97, 98, 99, 100)));
        step(0, 0, '0, 2'b00, 1, 0, 1);
        check("bp_delivered", 64'(delivered - start_del), 64'd2);

        // Saturation: clear, then preset to 65534
        step(0, 0, '0, 2'b00, 1, 1, 1);
        for (int i = 0; i < 16383; i++) step(0, 1, pack(97, 66, 120, 89), 2'b11, 1, 0, 0);
        step(0, 1, pack(97, 66, 33, 44), 2'b11, 1, 0, 1);
        check("preset_65534", 64'(conv_count), 64'd65534);
        step(0, 1, pack(97, 98, 99, 100), 2'b01, 1, 0, 1);
        check("saturate", 64'(conv_count), 64'd65535);
        step(0, 1, pack(97, 98, 99, 100), 2'b01, 1, 0, 1);
        check("saturate_hold", 64'(conv_count), 64'd65535);
        step(0, 1, pack(119, 120, 121, 122), 2'b01, 1, 1, 1);
        check("clr_same_edge", 64'(conv_count), 64'd0);
        check("clr_beat_data", 64'(m_data), 64'(pack(87, 88, 89, 90)));

        // Reset while stalled
        step(0, 1, pack(97, 98, 99, 100), 2'b01, 0, 0, 1);
        step(1, 1, pack(97, 98, 99, 100), 2'b01, 0, 0, 1);
        check("rst_stall_valid", 64'(m_valid), 64'd0);
        step(1, 1, pack(97, 98, 99, 100), 2'b01, 1, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rand_data(),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_case_stream.md
ASCII_CASE_STREAM -- requirements
Module: ascii_case_stream

Interface
REQ-001 Parameter LANES, default 4, number of 8-bit characters per beat (1..16).
REQ-002 Parameter CNT_W, default 16, width of the converted-character counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 mode  in  2  conversion mode, sampled with each accepted input beat: 00 pass, 01 upper, 10 lower, 11 toggle case.
REQ-007 s_valid  in  1  input beat valid.
REQ-008 s_ready  out  1  block can accept an input beat.
REQ-009 s_data  in  8*LANES  input characters; lane k = bits [8k+7:8k], lane 0 is first in stream order.
REQ-010 m_valid  out  1  output beat valid.
REQ-011 m_ready  in  1  downstream accepts the output beat.
REQ-012 m_data  out  8*LANES  converted characters, same lane order as input.
REQ-013 cnt_clr  in  1  clears conv_count.
REQ-014 conv_count  out  CNT_W  number of characters changed since reset/clear.

Function
REQ-015 An input beat SHALL be accepted on a rising edge where s_valid && s_ready; an output beat SHALL be transferred where m_valid && m_ready.
REQ-016 s_ready SHALL equal (!m_valid || m_ready), combinationally; single output register stage, no other buffering.
REQ-017 An accepted beat SHALL appear on m_data with m_valid=1 at the next edge (latency 1 cycle); full throughput of one beat per cycle while m_ready=1.
REQ-018 While m_valid=1 && m_ready=0, m_data and m_valid SHALL hold unchanged and no input is accepted.
REQ-019 If no beat is accepted and the output beat is transferred, m_valid SHALL go 0 at that edge; m_data holds its last value.
REQ-020 Per lane, independently: a byte in 'a'..'z' (97..122) is lowercase; a byte in 'A'..'Z' (65..90) is uppercase; all other bytes (0..64, 91..96, 123..255, including 128..255) are non-letters.
REQ-021 Mode 00: byte unchanged. Mode 01: lowercase byte minus 32, else unchanged. Mode 10: uppercase byte plus 32, else unchanged. Mode 11: lowercase minus 32, uppercase plus 32, else unchanged.
REQ-022 Non-letter bytes SHALL never be modified in any mode.
REQ-023 The mode applied to a beat SHALL be the mode value at the accepting edge; mode changes never alter a beat already in the output register.
REQ-024 On each accepting edge conv_count SHALL increase by the number of lanes whose byte was changed (0..LANES).
REQ-025 conv_count SHALL saturate at 2^CNT_W-1; it never wraps.
REQ-026 cnt_clr=1 at an edge SHALL set conv_count to 0, discarding any increment from a beat accepted on the same edge; the beat itself is still converted and output.
REQ-027 m_data SHALL be driven only from registers; no combinational path from s_data to m_data.

Reset
REQ-028 With rst=1 at an edge: m_valid=0, m_data=0, conv_count=0; any beat held in the output register is discarded.
REQ-029 While rst=1, s_ready SHALL be 0 and no beat is accepted, regardless of s_valid/m_ready.
REQ-030 rst has priority over cnt_clr, s_valid and m_ready; first acceptance possible on the first edge after rst deasserts.

Verification (LANES=4, CNT_W=16; bytes listed lane0..lane3)
REQ-031 Mode 01, beat {40,72,183,131}, m_ready=1 -> next cycle m_data {40,72,183,131}, m_valid=1, conv_count unchanged (0).
REQ-032 Mode 01, beat {97,122,109,71} -> m_data {65,90,77,71}, conv_count +3; same beat in mode 10 -> {97,122,109,103}, +1; mode 11 -> {65,90,77,103}, +4; mode 00 -> unchanged, +0.
REQ-033 Back-pressure: m_ready=0 for 3 cycles after a beat with s_valid held high -> s_ready=0, m_data stable all 3 cycles; m_ready=1 -> both beats delivered in order, none lost or duplicated.
REQ-034 Boundary bytes in mode 11: {64,91,96,123} unchanged, {65,90,97,122} -> {97,122,65,90}; bytes {207,235,146,148} unchanged in every mode.
REQ-035 conv_count preset to 65534 via 16383 mode-11 beats of four letters plus 2 changed bytes, then a beat with 4 changed -> 65535 and stays; cnt_clr on same edge as a 4-letter mode-01 beat -> 0, beat output converted.
REQ-036 rst asserted while m_valid=1 and m_ready=0 -> next edge m_valid=0, m_data=0, conv_count=0, s_ready=0 during reset.
